round_master: RTL
=================

Name: round_master

Overview:
- Initiator side of the game-round interface: drives the round strobe `freq` and the one-hot target `LED` into the hit detector.
- Consumes the detector's `hit`/`miss` verdicts to keep score and lives, and declares game over.
- Sits between the top-level start button and the hit detector; `score`, `lives_left` and `game_over` feed the display logic.

Parameters:
ROUND_CYCLES, 100000000, length of the lit window in clk cycles (detector checks its window at this count)
GAP_CYCLES, 25000000, dark cycles between rounds
LIVES, 3, lives at game start (1..15)
SCORE_W, 8, score counter width

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  level; sampled in IDLE/OVER to begin a game
hit  input  1  verdict from detector
miss  input  1  verdict from detector
freq  output  1  one-cycle round-start strobe
LED  output  8  one-hot target; 0 when no round lit
score  output  SCORE_W  rounds won, saturating
lives_left  output  4  remaining lives
game_over  output  1  high in OVER
state_out  output  3  debug: encoded FSM state (IDLE=0, GAP=1, ARM=2, ACTIVE=3, RESOLVE=4, OVER=5)

Behaviour:
- Reset (async, any state): state=IDLE; freq=0; LED=0; score=0; lives_left=0; game_over=0; cycle counter=0; lfsr=16'hACE1; prev_idx=0; hit_seen=miss_seen=0; miss_d=0.
- LFSR: 16-bit Galois, mask 16'hB400, shifts every clk in all states. Never zero. Candidate index idx=lfsr[2:0]; if idx==prev_idx use (idx+1) mod 8, so no target repeats consecutively.
- miss_rise = miss & ~miss_d. miss_d is registered every clk.
- IDLE: all outputs 0. If start=1 at the edge: score←0, lives_left←LIVES, counter←0, go to GAP.
- GAP: LED=0. Counter increments.
  - When counter==GAP_CYCLES-1: counter←0, go to ARM.
  - A miss_rise in GAP costs a life (false flip with light off): lives_left decrements, saturating at 0. If the result is 0, go to OVER that edge.
- ARM: exactly one cycle.
  - freq=1; LED=1<<chosen idx; prev_idx←chosen idx.
  - Clear hit_seen/miss_seen; counter←0; go to ACTIVE.
- ACTIVE: LED held; freq=0. Counter increments.
  - hit=1 sets hit_seen. miss_rise sets miss_seen. Both are sticky.
  - When counter==ROUND_CYCLES+1 (window is ROUND_CYCLES+2 cycles, covering the detector's last-cycle check plus 1 cycle of verdict latency): go to RESOLVE.
- RESOLVE: one cycle, LED still held.
  - Priority: miss_seen → lose a life. Else hit_seen → score+1, saturating at 2^SCORE_W-1. Else (timeout) → lose a life.
  - Verdict inputs in this cycle are also folded in, with the same priority.
  - Next state: OVER if lives_left becomes 0, else GAP with counter←0.
- OVER: game_over=1, LED=0, score and lives_left held. If start=1: reinitialise exactly as from IDLE and go to GAP.
- Simultaneous hit and miss_rise in the same cycle: both flags are set, so miss wins at RESOLVE.
- start is ignored outside IDLE/OVER.
- Reset mid-round: immediate return to IDLE; no freq pulse is emitted, and the LFSR restarts from the seed.
- Counter width: ceil(log2(max(ROUND_CYCLES+2, GAP_CYCLES)))+1 bits, enough that the terminal compare never wraps.

Test Plan (ROUND_CYCLES=20, GAP_CYCLES=5, LIVES=3):
- Reset then release, hold start=0 for 50 cycles → freq never 1, LED=0, state_out=0, game_over=0.
- start pulse at edge N → state_out=1 from N; freq=1 for exactly one cycle at N+5; LED is one-hot in that cycle and unchanged through the next 23 cycles; LED=0 in the following GAP.
- Pulse hit for 1 cycle at ACTIVE counter 21 → score=1, lives_left=3 after RESOLVE; next freq follows 5 GAP cycles later; next LED ≠ previous LED.
- Three rounds with no hit/miss → lives_left steps 3→2→1→0; game_over=1 after 3rd RESOLVE; score and LED stay 0; then start=1 → score=0, lives_left=3, GAP entered.
- Within one ACTIVE window: miss pulse at counter 5, hit pulse at counter 21 → miss wins, lives_left=2, score unchanged.
- Miss pulse during GAP with lives_left=1 → OVER on that edge with no freq emitted. Separately, assert rst at ACTIVE counter 10 → all outputs 0 immediately; 200 cycles of LED sequence show no consecutive repeats.

Source files
------------

// File: rtl/round_if.sv
// Game-round bus between the round master and the hit detector.
// Carries the start level, verdicts, round strobe, target and score outputs.
interface round_if #(
  parameter int SCORE_W = 8
);
  logic               start;
  logic               hit;
  logic               miss;
  logic               freq;
  logic [7:0]         LED;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives_left;
  logic               game_over;
  logic [2:0]         state_out;

  modport master (
    input  start,
    input  hit,
    input  miss,
    output freq,
    output LED,
    output score,
    output lives_left,
    output game_over,
    output state_out
  );

  modport slave (
    output start,
    output hit,
    output miss,
    input  freq,
    input  LED,
    input  score,
    input  lives_left,
    input  game_over,
    input  state_out
  );
endinterface

// File: rtl/round_master.sv
// Game-round initiator: lights a random one-hot target each round,
// collects hit/miss verdicts, keeps score and lives, declares game over.
module round_master #(
  parameter int ROUND_CYCLES = 100000000,
  parameter int GAP_CYCLES   = 25000000,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 8
) (
  input  logic     clk,
  input  logic     rst,
  round_if.master  bus
);

  localparam int MAXC =
    (ROUND_CYCLES + 2 > GAP_CYCLES) ? ROUND_CYCLES + 2 : GAP_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] RND_END = CW'(ROUND_CYCLES + 1);
  localparam logic [3:0]    LIVES_I = 4'(LIVES);
  localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GAP     = 3'd1,
    S_ARM     = 3'd2,
    S_ACTIVE  = 3'd3,
    S_RESOLVE = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [2:0]         prev_q, prev_d;
  logic [7:0]         led_q, led_d;
  logic               hseen_q, hseen_d;
  logic               mseen_q, mseen_d;
  logic               miss_d_q;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         lives_q, lives_d;

  logic [2:0]         idx_raw, idx;
  logic               miss_rise;
  logic [3:0]         lives_dec;
  logic               freq;
  logic [7:0]         led;
  logic               go;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400)
                            : (lfsr_q >> 1);

  // Bump the candidate so the same target never lights twice in a row
  assign idx_raw = lfsr_q[2:0];
  assign idx = (idx_raw == prev_q) ? idx_raw + 3'd1 : idx_raw;

  assign miss_rise = bus.miss & ~miss_d_q;
  assign lives_dec = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    led_d   = led_q;
    hseen_d = hseen_q;
    mseen_d = mseen_q;
    score_d = score_q;
    lives_d = lives_q;
    freq    = 1'b0;
    led     = 8'd0;
    go      = 1'b0;
    unique case (state_q)
      S_IDLE, S_OVER: begin
        go = (state_q == S_OVER);
        if (bus.start) begin
          score_d = '0;
          lives_d = LIVES_I;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = S_ARM;
        end
        // A flip with the light off costs a life
        if (miss_rise) begin
          lives_d = lives_dec;
          if (lives_dec == 4'd0) state_d = S_OVER;
        end
      end
      S_ARM: begin
        freq    = 1'b1;
        led     = 8'd1 << idx;
        led_d   = 8'd1 << idx;
        prev_d  = idx;
        hseen_d = 1'b0;
        mseen_d = 1'b0;
        cnt_d   = '0;
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        led   = led_q;
        cnt_d = cnt_q + CW'(1);
        if (bus.hit)   hseen_d = 1'b1;
        if (miss_rise) mseen_d = 1'b1;
        if (cnt_q == RND_END) state_d = S_RESOLVE;
      end
      S_RESOLVE: begin
        led   = led_q;
        cnt_d = '0;
        if (!(mseen_q | miss_rise) && (hseen_q | bus.hit)) begin
          score_d = (score_q == SMAX) ? score_q
                                      : score_q + SCORE_W'(1);
          state_d = S_GAP;
        end else begin
          lives_d = lives_dec;
          state_d = (lives_dec == 4'd0) ? S_OVER : S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      lfsr_q   <= 16'hACE1;
      prev_q   <= 3'd0;
      led_q    <= 8'd0;
      hseen_q  <= 1'b0;
      mseen_q  <= 1'b0;
      miss_d_q <= 1'b0;
      score_q  <= '0;
      lives_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      prev_q   <= prev_d;
      led_q    <= led_d;
      hseen_q  <= hseen_d;
      mseen_q  <= mseen_d;
      miss_d_q <= bus.miss;
      score_q  <= score_d;
      lives_q  <= lives_d;
    end
  end

  assign bus.freq       = freq;
  assign bus.LED        = led;
  assign bus.score      = score_q;
  assign bus.lives_left = lives_q;
  assign bus.game_over  = go;
  assign bus.state_out  = state_q;

endmodule
